// File: rtl/entropy_frame_sequencer.sv
// Frame sequencer for entropy_encoder: symbol stream in, flagged encoder beats out.
// Define SEQ_FLUSH_TIMEOUT_EN to bound the FLUSH wait by FLUSH_TIMEOUT cycles.
module entropy_frame_sequencer #(
  parameter int RANGE_WIDTH     = 16,
  parameter int SYMBOL_WIDTH    = 4,
  parameter int RESET_CYCLES    = 1,
  parameter int FLUSH_TIMEOUT   = 64,
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int SYM_CNT_WIDTH   = 24
) (
  input  logic                       top_clk,
  input  logic                       top_reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [RANGE_WIDTH-1:0]     in_fl,
  input  logic [RANGE_WIDTH-1:0]     in_fh,
  input  logic [SYMBOL_WIDTH-1:0]    in_symbol,
  input  logic [SYMBOL_WIDTH:0]      in_nsyms,
  input  logic                       in_bool,
  input  logic                       in_last,
  output logic                       enc_reset,
  output logic                       enc_valid,
  output logic                       enc_flag_first,
  output logic                       enc_final_flag,
  output logic [RANGE_WIDTH-1:0]     enc_fl,
  output logic [RANGE_WIDTH-1:0]     enc_fh,
  output logic [SYMBOL_WIDTH-1:0]    enc_symbol,
  output logic [SYMBOL_WIDTH:0]      enc_nsyms,
  output logic                       enc_bool,
  input  logic                       enc_flag_last,
  output logic                       frame_done,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic [SYM_CNT_WIDTH-1:0]   sym_count,
  output logic                       timeout_err
);

  localparam int RCW = $clog2(RESET_CYCLES + 1);

  if (RESET_CYCLES < 1 || FLUSH_TIMEOUT < 1) begin : g_bad_cfg
    $error("RESET_CYCLES and FLUSH_TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    ENC_RST,
    IDLE,
    RUN,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [RANGE_WIDTH-1:0]  fl;
    logic [RANGE_WIDTH-1:0]  fh;
    logic [SYMBOL_WIDTH-1:0] symbol;
    logic [SYMBOL_WIDTH:0]   nsyms;
    logic                    flag;
  } beat_t;

  state_t                     state, state_n;
  logic [RCW-1:0]             rst_cnt, rst_cnt_n;
  beat_t                      beat_q, beat_n, beat_in;
  logic                       accept;
  logic                       valid_n, first_n, done_n, terr_n;
  logic [FRAME_CNT_WIDTH-1:0] frames_n;
  logic [SYM_CNT_WIDTH-1:0]   syms_n;

`ifdef SEQ_FLUSH_TIMEOUT_EN
  localparam int FTW = $clog2(FLUSH_TIMEOUT + 1);
  logic [FTW-1:0] flush_cnt, flush_cnt_n;
`endif

  assign beat_in = '{fl: in_fl, fh: in_fh, symbol: in_symbol,
                     nsyms: in_nsyms, flag: in_bool};
  assign accept  = in_valid && in_ready;

  assign enc_fl     = beat_q.fl;
  assign enc_fh     = beat_q.fh;
  assign enc_symbol = beat_q.symbol;
  assign enc_nsyms  = beat_q.nsyms;
  assign enc_bool   = beat_q.flag;

  always_comb begin
    state_n   = state;
    rst_cnt_n = rst_cnt;
    beat_n    = beat_q;
    valid_n   = 1'b0;
    first_n   = 1'b0;
    done_n    = 1'b0;
    terr_n    = timeout_err;
    frames_n  = frame_count;
    syms_n    = sym_count;
`ifdef SEQ_FLUSH_TIMEOUT_EN
    flush_cnt_n = flush_cnt;
`endif
    unique case (state)
      ENC_RST: begin
        if (rst_cnt <= RCW'(1)) state_n = IDLE;
        else rst_cnt_n = rst_cnt - RCW'(1);
      end
      IDLE: begin
        if (accept) begin
          beat_n  = beat_in;
          valid_n = 1'b1;
          first_n = 1'b1;
          syms_n  = SYM_CNT_WIDTH'(1);
          state_n = in_last ? FLUSH : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          beat_n  = beat_in;
          valid_n = 1'b1;
          if (!(&sym_count)) syms_n = sym_count + SYM_CNT_WIDTH'(1);
          if (in_last) state_n = FLUSH;
        end
      end
      FLUSH: begin
        if (enc_flag_last) begin
          done_n    = 1'b1;
          frames_n  = frame_count + FRAME_CNT_WIDTH'(1);
          state_n   = ENC_RST;
          rst_cnt_n = RCW'(RESET_CYCLES);
        end
`ifdef SEQ_FLUSH_TIMEOUT_EN
        else if (flush_cnt == FTW'(FLUSH_TIMEOUT - 1)) begin
          terr_n    = 1'b1;
          state_n   = ENC_RST;
          rst_cnt_n = RCW'(RESET_CYCLES);
        end else begin
          flush_cnt_n = flush_cnt + FTW'(1);
        end
`endif
      end
      default: begin
        state_n   = ENC_RST;
        rst_cnt_n = RCW'(RESET_CYCLES);
      end
    endcase
`ifdef SEQ_FLUSH_TIMEOUT_EN
    // The counter only lives while FLUSH is held; every entry starts at zero.
    if (state_n != FLUSH) flush_cnt_n = '0;
`endif
  end

  always_ff @(posedge top_clk) begin
    if (!top_reset) begin
      state          <= ENC_RST;
      rst_cnt        <= RCW'(RESET_CYCLES);
      beat_q         <= '0;
      in_ready       <= 1'b0;
      enc_reset      <= 1'b1;
      enc_valid      <= 1'b0;
      enc_flag_first <= 1'b0;
      enc_final_flag <= 1'b0;
      frame_done     <= 1'b0;
      frame_count    <= '0;
      sym_count      <= '0;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_n;
      rst_cnt        <= rst_cnt_n;
      beat_q         <= beat_n;
      in_ready       <= (state_n == IDLE) || (state_n == RUN);
      enc_reset      <= (state_n == ENC_RST);
      enc_valid      <= valid_n;
      enc_flag_first <= first_n;
      enc_final_flag <= (state_n == FLUSH);
      frame_done     <= done_n;
      frame_count    <= frames_n;
      sym_count      <= syms_n;
      timeout_err    <= terr_n;
    end
  end

`ifdef SEQ_FLUSH_TIMEOUT_EN
  always_ff @(posedge top_clk) begin
    if (!top_reset) flush_cnt <= '0;
    else flush_cnt <= flush_cnt_n;
  end
`endif

endmodule

// File: tb/tb_entropy_frame_sequencer.sv
// Scoreboard bench for entropy_frame_sequencer with a small encoder flush model.
module tb_entropy_frame_sequencer;

  localparam int RW  = 16;
  localparam int SW  = 4;
  localparam int RC  = 1;
  localparam int FT  = 8;
  localparam int FCW = 16;
  localparam int SCW = 24;

  logic           clk = 1'b0;
  logic           top_reset = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [RW-1:0]  in_fl = '0;
  logic [RW-1:0]  in_fh = '0;
  logic [SW-1:0]  in_symbol = '0;
  logic [SW:0]    in_nsyms = '0;
  logic           in_bool = 1'b0;
  logic           in_last = 1'b0;
  logic           enc_reset, enc_valid, enc_flag_first, enc_final_flag;
  logic [RW-1:0]  enc_fl, enc_fh;
  logic [SW-1:0]  enc_symbol;
  logic [SW:0]    enc_nsyms;
  logic           enc_bool;
  logic           enc_flag_last = 1'b0;
  logic           frame_done;
  logic [FCW-1:0] frame_count;
  logic [SCW-1:0] sym_count;
  logic           timeout_err;

  always #5 clk = ~clk;

  entropy_frame_sequencer #(
    .RANGE_WIDTH(RW), .SYMBOL_WIDTH(SW), .RESET_CYCLES(RC),
    .FLUSH_TIMEOUT(FT), .FRAME_CNT_WIDTH(FCW), .SYM_CNT_WIDTH(SCW)
  ) dut (
    .top_clk(clk), .top_reset(top_reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fl(in_fl), .in_fh(in_fh), .in_symbol(in_symbol),
    .in_nsyms(in_nsyms), .in_bool(in_bool), .in_last(in_last),
    .enc_reset(enc_reset), .enc_valid(enc_valid),
    .enc_flag_first(enc_flag_first), .enc_final_flag(enc_final_flag),
    .enc_fl(enc_fl), .enc_fh(enc_fh), .enc_symbol(enc_symbol),
    .enc_nsyms(enc_nsyms), .enc_bool(enc_bool),
    .enc_flag_last(enc_flag_last), .frame_done(frame_done),
    .frame_count(frame_count), .sym_count(sym_count),
    .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [RW-1:0]  fl;
    logic [RW-1:0]  fh;
    logic [SW-1:0]  sym;
    logic [SW:0]    ns;
    logic           b;
    logic           first;
    logic [SCW-1:0] cnt;
  } exp_t;

  exp_t           exp_q[$];
  logic [FCW-1:0] fd_q[$];
  int             vectors = 0;
  int             errors = 0;
  bit             m_first = 1'b1;
  logic [SCW-1:0] m_cnt = '0;
  logic [FCW-1:0] m_frames = '0;
  exp_t           mon_e;
  logic           prev_done = 1'b0;
  int             w;
  int             n;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (enc_valid) begin
      check("valid_pending", 64'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("beat_fields",
              {enc_fl, enc_fh, enc_symbol, enc_nsyms, enc_bool},
              {mon_e.fl, mon_e.fh, mon_e.sym, mon_e.ns, mon_e.b});
        check("beat_first", enc_flag_first, mon_e.first);
        check("beat_symcnt", sym_count, mon_e.cnt);
      end
    end else if (enc_flag_first) begin
      check("first_without_valid", enc_flag_first, 0);
    end
    if (frame_done) begin
      check("done_pending", 64'(fd_q.size() > 0), 1);
      check("done_single", prev_done, 0);
      if (fd_q.size() > 0) check("frame_count", frame_count, fd_q.pop_front());
    end
    prev_done = frame_done;
  end

  task automatic beat(input logic [RW-1:0] fl, input logic [RW-1:0] fh,
                      input logic [SW-1:0] s, input logic [SW:0] ns,
                      input logic b, input logic last, output int waited);
    exp_t e;
    waited    = 0;
    in_valid  = 1'b1;
    in_fl     = fl;
    in_fh     = fh;
    in_symbol = s;
    in_nsyms  = ns;
    in_bool   = b;
    in_last   = last;
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("accept", in_ready, 1);
    if (in_ready) begin
      if (m_first) m_cnt = SCW'(1);
      else if (!(&m_cnt)) m_cnt = m_cnt + SCW'(1);
      e = '{fl: fl, fh: fh, sym: s, ns: ns, b: b, first: m_first, cnt: m_cnt};
      exp_q.push_back(e);
      m_first = last;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_reset();
    int r = 0;
    while (enc_reset && r < 20) begin
      r++;
      @(negedge clk);
    end
    check("enc_reset_len", r, RC);
    check("ready_after_reset", in_ready, 1);
  endtask

  // Encoder model: OUT_FLAG_LAST rises in the lat-th cycle of final_flag.
  task automatic flush(input int lat);
    int t = 0;
    while (!enc_final_flag && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("flush_entry", enc_final_flag, 1);
    check("flush_ready_low", in_ready, 0);
    repeat (lat - 1) @(negedge clk);
    check("final_held", enc_final_flag, 1);
    enc_flag_last = 1'b1;
    m_frames = m_frames + FCW'(1);
    fd_q.push_back(m_frames);
    @(negedge clk);
    enc_flag_last = 1'b0;
    check("final_drop", enc_final_flag, 0);
    check("enc_reset_on", enc_reset, 1);
    wait_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_enc_reset", enc_reset, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_counts", {frame_count, sym_count}, 0);
    check("rst_flags", {enc_valid, enc_final_flag, frame_done, timeout_err}, 0);
    top_reset = 1'b1;
    wait_reset();

    beat(16'd0, 16'd100, 4'd1, 5'd5, 1'b0, 1'b0, w);
    beat(16'd100, 16'd200, 4'd2, 5'd5, 1'b0, 1'b0, w);
    beat(16'd200, 16'd32768, 4'd3, 5'd5, 1'b0, 1'b1, w);
    flush(5);
    check("frame_a_count", frame_count, 1);
    check("frame_a_syms", sym_count, 3);

    beat(16'd10, 16'd20, 4'd4, 5'd9, 1'b1, 1'b0, w);
    repeat (2) begin
      @(negedge clk);
      check("bubble_valid", enc_valid, 0);
      check("bubble_hold", {enc_fl, enc_fh, enc_symbol}, {16'd10, 16'd20, 4'd4});
    end
    beat(16'd30, 16'd40, 4'd5, 5'd9, 1'b0, 1'b0, w);
    beat(16'd50, 16'd60, 4'd6, 5'd9, 1'b1, 1'b1, w);
    flush(2);
    check("bubble_syms", sym_count, 3);

    beat(16'd5, 16'd6, 4'd7, 5'd9, 1'b0, 1'b1, w);
    check("single_final", enc_final_flag, 1);
    fork
      flush(3);
      beat(16'd7, 16'd8, 4'd2, 5'd3, 1'b1, 1'b1, n);
    join
    check("stall_cycles", n, 3 + RC);
    flush(2);
    check("single_count", frame_count, 4);

    beat(16'd1, 16'd2, 4'd1, 5'd2, 1'b0, 1'b0, w);
    beat(16'd3, 16'd4, 4'd2, 5'd2, 1'b0, 1'b0, w);
    top_reset = 1'b0;
    @(negedge clk);
    check("mid_enc_reset", enc_reset, 1);
    check("mid_valid", enc_valid, 0);
    check("mid_counts", {frame_count, sym_count}, 0);
    top_reset = 1'b1;
    m_first  = 1'b1;
    m_frames = '0;
    wait_reset();
    beat(16'd9, 16'd11, 4'd3, 5'd4, 1'b0, 1'b1, w);
    flush(1);
    check("post_reset_count", frame_count, 1);

`ifdef SEQ_FLUSH_TIMEOUT_EN
    beat(16'd12, 16'd13, 4'd1, 5'd2, 1'b0, 1'b1, w);
    n = 0;
    while (enc_final_flag && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("timeout_len", n, FT);
    check("timeout_enc_reset", enc_reset, 1);
    check("timeout_err", timeout_err, 1);
    check("timeout_count", frame_count, m_frames);
    wait_reset();
    check("timeout_sticky", timeout_err, 1);
`else
    check("timeout_tied", timeout_err, 0);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size() + fd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/entropy_frame_sequencer.md
Name: entropy_frame_sequencer

Overview:
- Frame-level controller in front of entropy_encoder.
- Accepts per-symbol encoder inputs over a valid/ready stream with an end-of-frame marker, drives the encoder symbol ports with a per-beat enable, and generates top_flag_first and top_final_flag.
- Holds final_flag until the encoder returns OUT_FLAG_LAST, then pulses the encoder reset before the next frame.
- Removes frame bookkeeping from the integration top and benches.

Parameters:
- RANGE_WIDTH, 16, width of fl/fh.
- SYMBOL_WIDTH, 4, symbol width; nsyms is SYMBOL_WIDTH+1.
- RESET_CYCLES, 1, cycles enc_reset is held after each frame and after top_reset; must be ≥1.
- FLUSH_TIMEOUT, 64, max FLUSH cycles awaiting enc_flag_last (optional feature only).
- FRAME_CNT_WIDTH, 16, frame counter width.
- SYM_CNT_WIDTH, 24, per-frame symbol counter width.

Ports:
- top_clk  in  1  single clock.
- top_reset  in  1  synchronous, active-low reset.
- in_valid  in  1  symbol beat valid.
- in_ready  out  1  sequencer accepts beat.
- in_fl  in  RANGE_WIDTH  fl.
- in_fh  in  RANGE_WIDTH  fh.
- in_symbol  in  SYMBOL_WIDTH  symbol.
- in_nsyms  in  SYMBOL_WIDTH+1  nsyms.
- in_bool  in  1  boolean-symbol mode.
- in_last  in  1  beat is last symbol of frame.
- enc_reset  out  1  active-high reset to encoder.
- enc_valid  out  1  encoder stage enable; enc_* symbol fields are valid this cycle.
- enc_flag_first  out  1  to top_flag_first.
- enc_final_flag  out  1  to top_final_flag.
- enc_fl, enc_fh  out  RANGE_WIDTH  to top_fl/top_fh.
- enc_symbol  out  SYMBOL_WIDTH  to top_symbol.
- enc_nsyms  out  SYMBOL_WIDTH+1  to top_nsyms.
- enc_bool  out  1  to top_bool.
- enc_flag_last  in  1  from OUT_FLAG_LAST.
- frame_done  out  1  one-cycle pulse when a frame completes.
- frame_count  out  FRAME_CNT_WIDTH  completed frames; wraps.
- sym_count  out  SYM_CNT_WIDTH  symbols issued in current/last frame; saturates.
- timeout_err  out  1  sticky flush timeout.

Behaviour:
- All outputs registered.
- top_reset low (sampled on top_clk):
  - state ← ENC_RST, RESET_CYCLES counter loaded.
  - enc_reset=1; all other outputs 0, including counters, enc_* fields and timeout_err.
  - Any frame in progress is aborted.
- States: ENC_RST, IDLE, RUN, FLUSH.
- ENC_RST:
  - enc_reset=1, in_ready=0, enc_valid=0, enc_final_flag=0.
  - After RESET_CYCLES cycles → IDLE; enc_reset=0 from that cycle.
- IDLE:
  - in_ready=1.
  - Beat accepted (in_valid&in_ready) in cycle N: in cycle N+1, enc_* fields = beat, enc_valid=1, enc_flag_first=1, sym_count=1.
  - in_last=0 → RUN; in_last=1 → FLUSH.
- RUN:
  - in_ready=1.
  - Each accepted beat gives enc_valid=1 next cycle, enc_flag_first=0, sym_count+1 (saturating at all-ones).
  - Cycle with no accepted beat: enc_valid=0, enc_* fields hold last value.
  - Accepted beat with in_last=1 → FLUSH; in_ready=0 from the next cycle.
- FLUSH:
  - enc_final_flag=1, enc_valid=0, fields hold, in_ready=0.
  - On enc_flag_last=1: frame_done=1 for one cycle, frame_count+1 (modulo 2^FRAME_CNT_WIDTH), enc_final_flag=0 → ENC_RST.
- enc_flag_last outside FLUSH: ignored.
- in_valid held while in FLUSH/ENC_RST: beat is not consumed and remains pending.
- Throughput: one symbol per cycle; frame turnaround = flush latency + RESET_CYCLES + 1 (IDLE accept).
- A single-symbol frame is a first beat with in_last=1: flag_first=1, then FLUSH.
- sym_count holds after frame_done until the first beat of the next frame.

Optional Feature:
- Macro: SEQ_FLUSH_TIMEOUT_EN.
- Defined:
  - Counter runs in FLUSH.
  - After FLUSH_TIMEOUT cycles without enc_flag_last: timeout_err ← 1 (sticky until top_reset), enc_final_flag=0, → ENC_RST.
  - frame_done is not pulsed and frame_count is unchanged.
- Undefined: no counter; FLUSH waits indefinitely; timeout_err tied 0.

Test Plan:
- Reset: top_reset low 3 cycles → enc_reset=1, in_ready=0, counters 0; after release, enc_reset=1 for exactly RESET_CYCLES=1 cycle, then in_ready=1.
- 3-beat back-to-back frame (fl=0/100/200, fh=100/200/32768, last on beat 3), model raises enc_flag_last 5 cycles after final_flag → enc_valid high 3 cycles, flag_first only on beat 1, final_flag high 5 cycles, frame_done single pulse, frame_count=1, sym_count=3, enc_reset 1 cycle.
- Bubbles: in_valid pattern 1,0,0,1,1(last) → enc_valid 1,0,0,1,1; fields hold during gaps; sym_count=3.
- Single-symbol frame with in_last on the first beat → flag_first=1 and final_flag asserted next cycle; next frame's beat stalls (in_ready=0) until after enc_reset.
- SEQ_FLUSH_TIMEOUT_EN, FLUSH_TIMEOUT=8, enc_flag_last never asserted → timeout_err=1 after 8 FLUSH cycles, enc_reset asserted, frame_count unchanged, no frame_done.
- top_reset low mid-RUN (after 2 beats) → next cycle enc_reset=1, enc_valid=0, frame_count=0; following frame starts with flag_first=1.
